ps2_rx_fifo_ctrl: RTL

//   Parametrised PS/2 device-to-host receiver: synchronises and glitch-filters ps2_clk/ps2_data,

---
 rtl/ps2_rx_fifo_ctrl_pkg.sv | 18 +
 rtl/ps2_defs.vh | 9 +
 rtl/ps2_sync_fifo.sv | 70 +++++++
 rtl/ps2_rx_fifo_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ps2_rx_fifo_ctrl_pkg.sv
// rtl/ps2_rx_fifo_ctrl_pkg.sv - PS/2 receiver types, constants and frame check helpers
package ps2_rx_fifo_ctrl_pkg;
  `include "ps2_defs.vh"

  localparam int PS2_LAST_BIT = PS2_FRAME_BITS - 1;

  typedef logic [PS2_CODE_W-1:0] ps2_code_t;

  // Start must be 0 and stop must be 1.
  function automatic logic ps2_framing_ok(input logic start_bit, input logic stop_bit);
    return ~start_bit & stop_bit;
  endfunction

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input ps2_code_t code, input logic par);
    return ^{code, par};
  endfunction
endpackage

// File: rtl/ps2_defs.vh
// rtl/ps2_defs.vh - shared PS/2 frame geometry and scan-code constants
`ifndef PS2_DEFS_VH
`define PS2_DEFS_VH
localparam int PS2_FRAME_BITS = 11;
localparam int PS2_CODE_W     = 8;
// Prefix codes consumed by the downstream scan-code decoder.
localparam logic [7:0] PS2_BREAK = 8'hF0;
localparam logic [7:0] PS2_EXT   = 8'hE0;
`endif

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - show-ahead synchronous FIFO with drop/overwrite full policy
// Ports: clk, clr (sync active-high); push/din write side; pop/dout read side (show-ahead);
//        level (0..2**DEPTH_LOG2), full, empty (registered); drop pulses when a byte is lost.
module ps2_sync_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8,
  parameter int OVERWRITE  = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  // Pointers carry one extra MSB so w-r distinguishes full from empty.
  logic [DEPTH_LOG2:0] w_ptr, r_ptr, w_nxt, r_nxt, lvl_nxt;
  logic                pop_ok, wr_en, adv_r;

  always_comb begin
    pop_ok = pop & ~empty;
    wr_en  = 1'b0;
    adv_r  = pop_ok;
    drop   = 1'b0;
    if (push) begin
      // A simultaneous pop frees a slot, so only an unpopped full FIFO loses data.
      if (full && !pop_ok) begin
        drop = 1'b1;
        if (OVERWRITE != 0) begin
          wr_en = 1'b1;
          adv_r = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
      end
    end
    w_nxt   = w_ptr + {{DEPTH_LOG2{1'b0}}, wr_en};
    r_nxt   = r_ptr + {{DEPTH_LOG2{1'b0}}, adv_r};
    lvl_nxt = w_nxt - r_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      w_ptr <= w_nxt;
      r_ptr <= r_nxt;
      level <= lvl_nxt;
      empty <= (lvl_nxt == '0);
      full  <= lvl_nxt[DEPTH_LOG2];
    end
  end

  assign dout = mem[r_ptr[DEPTH_LOG2-1:0]];
endmodule

// File: rtl/ps2_rx_fifo_ctrl.sv
// rtl/ps2_rx_fifo_ctrl.sv - PS/2 device-to-host receiver with glitch filter, deframer and scan-code FIFO
// Ports: clk, clr (sync active-high); ps2_clk/ps2_data raw pins; rd_en pops the head;
//        data/ready/level show the FIFO head and occupancy; frame_valid pulses per good frame;
//        overflow/parity_err/frame_err sticky, cleared by err_clr.
module ps2_rx_fifo_ctrl
  import ps2_rx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int OVERWRITE   = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  rd_en,
  output logic [7:0]            data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  frame_valid,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err,
  input  logic                  err_clr
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Index 0 = clock line, 1 = data line; both take the same path so they stay aligned.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_f_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      clk_f_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1   <= {ps2_data, ps2_clk};
      sync2   <= sync1;
      clk_f_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the filtered value.
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic        strobe, bit_in;
  logic [3:0]  bit_cnt;
  // Right shift: after ten bits, [0]=start, [8:1]=code, [9]=parity.
  logic [9:0]  shreg;
  logic [TW-1:0] to_cnt;
  logic        last_bit, frm_ok, par_ok, good, perr_set, ferr_set, timeout_hit;
  logic        fifo_drop, fifo_empty, fifo_full;
  ps2_code_t   code;

  always_comb begin
    strobe      = clk_f_d & ~filt[0];
    bit_in      = filt[1];
    code        = shreg[8:1];
    last_bit    = strobe && (bit_cnt == 4'(PS2_LAST_BIT));
    frm_ok      = ps2_framing_ok(shreg[0], bit_in);
    par_ok      = ps2_parity_ok(code, shreg[9]);
    good        = last_bit && frm_ok && par_ok;
    perr_set    = last_bit && frm_ok && !par_ok;
    timeout_hit = (bit_cnt != 4'd0) && !strobe && (to_cnt == TW'(TIMEOUT_CYC - 1));
    ferr_set    = (last_bit && !frm_ok) || timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (strobe) begin
        to_cnt <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
        end else begin
          shreg   <= {bit_in, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout_hit) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
      frame_valid <= good;
      // A new error in the clearing cycle wins over err_clr.
      overflow    <= (overflow   & ~err_clr) | fifo_drop;
      parity_err  <= (parity_err & ~err_clr) | perr_set;
      frame_err   <= (frame_err  & ~err_clr) | ferr_set;
    end
  end

  ps2_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (PS2_CODE_W),
    .OVERWRITE  (OVERWRITE)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (good),
    .din   (code),
    .pop   (rd_en),
    .dout  (data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign ready = ~fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;
endmodule
